// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus a
// per-register busy scoreboard used by decode for RAW hazard detection.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,

    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,

    input  logic        rsv_valid,
    input  logic [4:0]  rsv_rd,
    input  logic        flush,
    output logic [31:0] busy,

    output logic        rf_write_enable,
    output logic [4:0]  rf_addr_3,
    output logic [31:0] rf_write_data
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    grant_t      last_grant;
    logic        accept;
    logic        write_rf;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data;
    logic [31:0] busy_q;
    logic [31:0] busy_next;

    // Ready depends only on the two valids and last_grant, never on rd/data.
    always_comb begin
        a_ready = a_valid && (!b_valid || (last_grant == GRANT_B));
        b_ready = b_valid && (!a_valid || (last_grant == GRANT_A));
    end

    assign accept   = a_ready || b_ready;
    assign acc_rd   = a_ready ? a_rd   : b_rd;
    assign acc_data = a_ready ? a_data : b_data;
    assign write_rf = accept && (acc_rd != 5'd0);

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        busy_next = busy_q;
        if (flush) begin
            busy_next = '0;
        end else begin
            if (accept) begin
                busy_next[acc_rd] = 1'b0;
            end
            // A same-cycle reservation belongs to a younger instruction, so it wins.
            if (rsv_valid) begin
                busy_next[rsv_rd] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant      <= GRANT_B;
            busy_q          <= '0;
            rf_write_enable <= 1'b0;
            rf_addr_3       <= '0;
            rf_write_data   <= '0;
        end else begin
            busy_q          <= busy_next;
            rf_write_enable <= write_rf;
            if (accept) begin
                last_grant <= a_ready ? GRANT_A : GRANT_B;
            end
            // Address and data hold when nothing (or only an x0 write) is accepted.
            if (write_rf) begin
                rf_addr_3     <= acc_rd;
                rf_write_data <= acc_data;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed reset sequence, a table of
// scripted cycles, and randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, rsv_valid, flush;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, rsv_rd;
    logic [31:0] a_data, b_data;
    logic [31:0] busy;
    logic        rf_write_enable;
    logic [4:0]  rf_addr_3;
    logic [31:0] rf_write_data;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_rd            (a_rd),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_rd            (b_rd),
        .b_data          (b_data),
        .rsv_valid       (rsv_valid),
        .rsv_rd          (rsv_rd),
        .flush           (flush),
        .busy            (busy),
        .rf_write_enable (rf_write_enable),
        .rf_addr_3       (rf_addr_3),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        a_valid;
        logic [4:0]  a_rd;
        logic [31:0] a_data;
        logic        b_valid;
        logic [4:0]  b_rd;
        logic [31:0] b_data;
        logic        rsv_valid;
        logic [4:0]  rsv_rd;
        logic        flush;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_busy;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        rsv_valid = 0; rsv_rd = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_we",   {31'd0, rf_write_enable}, 32'd0);
        check("reset_addr", {27'd0, rf_addr_3}, 32'd0);
        check("reset_data", rf_write_data, 32'd0);
        check("reset_busy", busy, 32'd0);
    endtask

    // Behavioural model state for the random phase
    bit          m_last_was_a;
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    function automatic logic [31:0] model_busy_word();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = m_busy[i];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // ---------------- reset asserted mid-stream ----------------
        do_reset();
        a_valid = 1; a_rd = 5'd5; a_data = 32'h0000_ABCD;
        rsv_valid = 1; rsv_rd = 5'd9;
        @(posedge clk); #1;
        check("pre_rst_we",   {31'd0, rf_write_enable}, 32'd1);
        check("pre_rst_busy", busy, 32'h0000_0200);
        rsv_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_we",   {31'd0, rf_write_enable}, 32'd0);
        check("async_rst_addr", {27'd0, rf_addr_3}, 32'd0);
        check("async_rst_data", rf_write_data, 32'd0);
        check("async_rst_busy", busy, 32'd0);
        a_valid = 1; a_rd = 5'd6; a_data = 32'h66;
        b_valid = 1; b_rd = 5'd7; b_data = 32'h77;
        #3 rst_n = 1'b1;
        #1;
        check("first_grant_a_ready", {31'd0, a_ready}, 32'd1);
        check("first_grant_b_ready", {31'd0, b_ready}, 32'd0);
        @(posedge clk); #1;
        check("first_grant_addr", {27'd0, rf_addr_3}, 32'd6);
        check("first_grant_data", rf_write_data, 32'h66);

        // ---------------- table-driven scripted cycles ----------------
        //            a_v  a_rd   a_data          b_v  b_rd   b_data          rsv  rsv_rd fl   ar   br   we   addr   data            busy
        vecs[0]  = '{1'b1, 5'd1,  32'd100,        1'b1, 5'd11, 32'd200,       1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  32'd100,        32'h0};
        vecs[1]  = '{1'b1, 5'd2,  32'd101,        1'b1, 5'd11, 32'd200,       1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'd200,        32'h0};
        vecs[2]  = '{1'b1, 5'd2,  32'd101,        1'b1, 5'd12, 32'd201,       1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  32'd101,        32'h0};
        vecs[3]  = '{1'b1, 5'd3,  32'd102,        1'b1, 5'd12, 32'd201,       1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'd201,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 32'd201,        32'h0};
        vecs[5]  = '{1'b1, 5'd3,  32'hFFFF_FFFF,  1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'hFFFF_FFFF,  32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'hFFFF_FFFF,  32'h0};
        vecs[7]  = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'hFFFF_FFFF,  32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd3,  32'hFFFF_FFFF,  32'h0};
        vecs[9]  = '{1'b1, 5'd4,  32'd5,          1'b1, 5'd5,  32'd6,         1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 5'd4,  32'd5,          32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 5'd4,  32'd5,          32'h80};
        vecs[11] = '{1'b1, 5'd7,  32'd77,         1'b0, 5'd0,  32'd0,         1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  32'd77,         32'h80};
        vecs[12] = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd7,  32'd78,        1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'd78,         32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'd78,         32'h2};
        vecs[14] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'd78,         32'h6};
        vecs[15] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  32'd78,         32'h8000_0006};
        vecs[16] = '{1'b1, 5'd1,  32'h11,         1'b0, 5'd0,  32'd0,         1'b1, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1, 5'd1,  32'h11,         32'h0};
        vecs[17] = '{1'b0, 5'd0,  32'd0,          1'b1, 5'd2,  32'h22,        1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'd2,  32'h22,         32'h0};
        vecs[18] = '{1'b0, 5'd0,  32'd0,          1'b0, 5'd0,  32'd0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  32'h22,         32'h0};

        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            a_valid = vecs[i].a_valid; a_rd = vecs[i].a_rd; a_data = vecs[i].a_data;
            b_valid = vecs[i].b_valid; b_rd = vecs[i].b_rd; b_data = vecs[i].b_data;
            rsv_valid = vecs[i].rsv_valid; rsv_rd = vecs[i].rsv_rd; flush = vecs[i].flush;
            #1;
            check($sformatf("vec%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].exp_a_ready});
            check($sformatf("vec%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].exp_b_ready});
            @(posedge clk); #1;
            check($sformatf("vec%0d_we", i),   {31'd0, rf_write_enable}, {31'd0, vecs[i].exp_we});
            check($sformatf("vec%0d_addr", i), {27'd0, rf_addr_3}, {27'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_data", i), rf_write_data, vecs[i].exp_data);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // ---------------- randomized traffic vs model ----------------
        do_reset();
        m_last_was_a = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we = 1'b0; m_addr = '0; m_data = '0;
        begin
            int a_wait = 0;
            int b_wait = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                bit exp_a, exp_b, acc;
                logic [4:0]  acc_rd;
                logic [31:0] acc_data;
                // A requester holds its request until accepted, then may raise a new one.
                if (!a_valid && ($urandom_range(0, 2) != 0)) begin
                    a_valid = 1; a_rd = 5'($urandom_range(0, 31)); a_data = $urandom;
                end
                if (!b_valid && ($urandom_range(0, 2) != 0)) begin
                    b_valid = 1; b_rd = 5'($urandom_range(0, 31)); b_data = $urandom;
                end
                rsv_valid = ($urandom_range(0, 1) == 1);
                rsv_rd    = 5'($urandom_range(0, 31));
                flush     = ($urandom_range(0, 19) == 0);
                #1;
                // Round robin: a lone requester always wins; on conflict the one not served last wins.
                if (a_valid && b_valid) begin
                    exp_a = !m_last_was_a;
                    exp_b = m_last_was_a;
                end else begin
                    exp_a = a_valid;
                    exp_b = b_valid;
                end
                check("rnd_a_ready", {31'd0, a_ready}, {31'd0, exp_a});
                check("rnd_b_ready", {31'd0, b_ready}, {31'd0, exp_b});
                acc      = exp_a || exp_b;
                acc_rd   = exp_a ? a_rd : b_rd;
                acc_data = exp_a ? a_data : b_data;
                if (acc) m_last_was_a = exp_a;
                if (flush) begin
                    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
                end else begin
                    if (acc) m_busy[acc_rd] = 1'b0;
                    if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
                end
                m_we = acc && (acc_rd != 0);
                if (m_we) begin
                    m_addr = acc_rd;
                    m_data = acc_data;
                end
                a_wait = (a_valid && !exp_a) ? a_wait + 1 : 0;
                b_wait = (b_valid && !exp_b) ? b_wait + 1 : 0;
                if (a_wait > 1 || b_wait > 1)
                    check("rnd_starvation", 32'(a_wait > b_wait ? a_wait : b_wait), 32'd1);
                @(posedge clk); #1;
                check("rnd_we",   {31'd0, rf_write_enable}, {31'd0, m_we});
                check("rnd_addr", {27'd0, rf_addr_3}, {27'd0, m_addr});
                check("rnd_data", rf_write_data, m_data);
                check("rnd_busy", busy, model_busy_word());
                if (exp_a) a_valid = 0;
                if (exp_b) b_valid = 0;
            end
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32 x 32-bit register file. Two producers share the register file's single write port (addr_3 / write_data / write_enable): requester A is the execute (ALU) result and requester B is the load-return path. The block grants the port with fair round-robin arbitration and registers the winning write. It also keeps a busy bit per architectural register, so decode can detect read-after-write hazards against writes that are still in flight.

## Interface
- No parameters. Register count 32, data width 32 and address width 5 are fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  execute requester has a write pending
- a_ready  out  1  execute write accepted this cycle (combinational)
- a_rd  in  5  execute destination register
- a_data  in  32  execute result
- b_valid  in  1  load requester has a write pending
- b_ready  out  1  load write accepted this cycle (combinational)
- b_rd  in  5  load destination register
- b_data  in  32  load data
- rsv_valid  in  1  decode issues an instruction that will write rsv_rd
- rsv_rd  in  5  register to mark busy
- flush  in  1  synchronous clear of all busy bits (pipeline flush)
- busy  out  32  busy[i]=1 means a write to xi is reserved and not yet accepted; busy[0] is always 0
- rf_write_enable  out  1  to reg_file write_enable
- rf_addr_3  out  5  to reg_file addr_3
- rf_write_data  out  32  to reg_file write_data

## Operation
- Arbiter state: a 1-bit last_grant (A or B).
- Only A valid: a_ready=1. Only B valid: b_ready=1. Neither valid: both ready=0.
- Both valid: grant the requester not in last_grant; the other sees ready=0 and holds its request. last_grant updates on every accepted handshake.
- Ready never depends on an input other than a_valid, b_valid and last_grant. At most one ready is high per cycle.
- Accepted write to rd!=0: on the next edge, rf_write_enable=1, rf_addr_3=rd, rf_write_data=data.
- Accepted write to rd=0: the handshake completes and last_grant updates. On the next edge rf_write_enable=0, and rf_addr_3 and rf_write_data keep their previous values.
- No accept this cycle: rf_write_enable=0 on the next edge, and rf_addr_3 and rf_write_data hold their previous values.
- Scoreboard, evaluated per edge and per register i:
  - flush=1: all bits clear, overriding everything else, including the same-cycle rsv.
  - Otherwise, set if rsv_valid and rsv_rd==i and i!=0.
  - Otherwise, clear if an accept occurs with rd==i.
  - Set wins over clear for the same register in the same cycle, because the new reservation belongs to a younger instruction.
- A write accepted for a register that is not busy is legal: it is written and busy is unchanged.

## Timing
- Reset values (asynchronous on rst_n=0, held while low):
  - rf_write_enable=0, rf_addr_3=0, rf_write_data=0
  - busy=32'h0000_0000
  - last_grant=B, so A wins the first conflict
- Any registered write pending at reset is dropped.
- Latency is 1 cycle: a handshake sampled at edge N drives rf_write_enable high for exactly the cycle between edges N and N+1. The reg_file commits it during that cycle.
- Busy clears at the same edge N as acceptance. From edge N onward, decode sees busy=0. Decode must not read the reg_file for that register before edge N+1; the pipeline guarantees this with one cycle of bypass or stall.
- Back-to-back accepts produce back-to-back rf_write_enable pulses with no bubble.
- Under continuous contention, grants alternate A,B,A,B... Neither requester waits more than 1 cycle.
- A requester must hold valid, rd and data stable until its ready is high.

## Test plan
- Reset: assert rst_n=0 mid-stream with a_valid=1, a_rd=5 -> immediately rf_write_enable=0, rf_addr_3=0, rf_write_data=0, busy=0. After release with both requesters valid, the first grant goes to A.
- Single write: a_valid=1, a_rd=3, a_data=32'hFFFF_FFFF for one cycle -> a_ready=1. Next cycle rf_write_enable=1, rf_addr_3=3, rf_write_data=32'hFFFF_FFFF; the cycle after, rf_write_enable=0.
- Contention: both requesters valid for 4 cycles (A rd=1..4, B rd=11..14, each advancing on its own grant) -> grants A,B,A,B. The write stream is x1,x11,x2,x12 with four consecutive enable pulses.
- x0 handling: rsv_rd=0 gives busy[0]=0. b_valid=1, b_rd=0, b_data=32'hDEAD_BEEF -> b_ready=1, rf_write_enable stays 0, last_grant becomes B.
- Scoreboard: rsv x7 -> busy[7]=1. A write to x7 accepted in the same cycle as a new rsv x7 -> busy[7] stays 1. A later accept of x7 with no rsv -> busy[7]=0.
- Flush: reserve x1, x2 and x31, then flush=1 with a simultaneous rsv x9 -> busy=0 next cycle. Pending handshakes still write normally.
